gpio_pixel_unpacker: RTL

Receiving end of the memory stage's GPIO output port. Captures the 128-bit GPIO word once per colour channel, qualified by the R/G/B enable strobes, and serialises the three captured words into 16 RGB888 pixels on a valid/ready stream. It sits on the board side of the ASIP and feeds a display or host link. The frame-end strobe closes the frame with a `pix_last` marker and a `frame_done` pulse.

---
 rtl/gpio_pixel_unpacker.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/gpio_pixel_unpacker.sv
// gpio_pixel_unpacker
//
// Board-side receiver for the memory stage GPIO port. Captures one 128-bit
// word per colour channel (R, G, B strobes), then streams the three words
// out as 16 RGB888 pixels on a valid/ready interface, lane 0 first. The
// frame-end strobe marks the final pixel with pix_last and pulses frame_done.
//
// Build option: define GPIO_UNPACK_OVF_EN to build the sticky overflow flag
// (set when a channel strobe is dropped while busy). Without it, ovf is tied
// to 0 and ovf_clr is ignored.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   GPIO                data word from the memory stage
//   GPIOEnR/G/B         single-cycle channel capture strobes
//   GPIOEn              single-cycle frame-end strobe
//   pix_data/valid      pixel stream {R,G,B}, held while pix_ready is low
//   pix_ready           downstream accept
//   pix_last            final pixel of the frame (qualified by pix_valid)
//   frame_done          one-cycle end-of-frame pulse
//   busy                high outside COLLECT; channel strobes are dropped
//   word_count          RGB words emitted in the current frame
//   ovf, ovf_clr        sticky dropped-strobe flag and its clear
//
// state   | meaning
// --------+---------------------------------------------------------------
// COLLECT | accepting channel captures, waiting for a full R/G/B set
// EMIT    | streaming lanes 0..LANES-1 of the captured set
// DONE    | one-cycle frame_done pulse, then back to COLLECT

module gpio_pixel_unpacker #(
    parameter int LANES = 16,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [8*LANES-1:0] GPIO,
    input  logic               GPIOEnR,
    input  logic               GPIOEnG,
    input  logic               GPIOEnB,
    input  logic               GPIOEn,
    output logic [23:0]        pix_data,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic               pix_last,
    output logic               frame_done,
    output logic               busy,
    output logic [CNT_W-1:0]   word_count,
    output logic               ovf,
    input  logic               ovf_clr
);

    localparam int LW = $clog2(LANES);

    typedef enum logic [1:0] {COLLECT, EMIT, DONE} state_t;

    state_t               state;
    logic [8*LANES-1:0]   bufR, bufG, bufB;
    logic                 fR, fG, fB;
    logic                 end_pend;
    logic                 wc_hold;   // word_count is stale from the last frame
    logic [LW-1:0]        lane;

    logic                 any_strobe;
    logic                 nR, nG, nB;
    logic                 last_lane;
    logic [LW+2:0]        bit_base;

    assign any_strobe = GPIOEnR | GPIOEnG | GPIOEnB;
    assign nR         = fR | GPIOEnR;
    assign nG         = fG | GPIOEnG;
    assign nB         = fB | GPIOEnB;
    assign last_lane  = (lane == LW'(LANES - 1));
    assign bit_base   = {lane, 3'b000};

    assign pix_valid  = (state == EMIT);
    assign pix_data   = pix_valid ? {bufR[bit_base +: 8], bufG[bit_base +: 8], bufB[bit_base +: 8]}
                                  : 24'h0;
    assign pix_last   = pix_valid & last_lane & end_pend;
    assign frame_done = (state == DONE);
    assign busy       = (state != COLLECT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= COLLECT;
            bufR       <= '0;
            bufG       <= '0;
            bufB       <= '0;
            fR         <= 1'b0;
            fG         <= 1'b0;
            fB         <= 1'b0;
            end_pend   <= 1'b0;
            wc_hold    <= 1'b0;
            lane       <= '0;
            word_count <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (GPIOEnR) bufR <= GPIO;
                    if (GPIOEnG) bufG <= GPIO;
                    if (GPIOEnB) bufB <= GPIO;
                    fR <= nR;
                    fG <= nG;
                    fB <= nB;
                    // First capture of a new frame restarts the word count.
                    if (any_strobe && wc_hold) begin
                        word_count <= '0;
                        wc_hold    <= 1'b0;
                    end
                    if (GPIOEn) end_pend <= 1'b1;
                    if (fR && fG && fB) begin
                        state <= EMIT;
                        lane  <= '0;
                    end else if ((end_pend || GPIOEn) && !(nR || nG || nB)) begin
                        // Frame end with nothing captured: close immediately.
                        state <= DONE;
                    end
                end
                EMIT: begin
                    if (GPIOEn) end_pend <= 1'b1;
                    if (pix_ready) begin
                        lane <= lane + 1'b1;
                        if (last_lane) begin
                            fR         <= 1'b0;
                            fG         <= 1'b0;
                            fB         <= 1'b0;
                            word_count <= word_count + 1'b1;
                            state      <= end_pend ? DONE : COLLECT;
                        end
                    end
                end
                DONE: begin
                    end_pend <= 1'b0;
                    wc_hold  <= 1'b1;
                    state    <= COLLECT;
                end
                default: state <= COLLECT;
            endcase
        end
    end

`ifdef GPIO_UNPACK_OVF_EN
    always_ff @(posedge clk) begin
        if (rst)
            ovf <= 1'b0;
        else if (busy && any_strobe)
            ovf <= 1'b1;
        else if (ovf_clr)
            ovf <= 1'b0;
    end
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign ovf            = 1'b0;
`endif

endmodule
